// File: rtl/special_reg_bank_if.sv
// Decode/writeback-side bundle for the special register bank: write strobes and data in,
// register contents and return-stack status out.
interface special_reg_bank_if #(
  parameter int WIDTH    = 16,
  parameter int RA_DEPTH = 4,
  parameter int CW       = $clog2(RA_DEPTH + 1)
) ();
  logic             write_hi;
  logic             write_lo;
  logic             write_at;
  logic [WIDTH-1:0] hi_i;
  logic [WIDTH-1:0] lo_i;
  logic [WIDTH-1:0] at_i;
  logic             ra_push;
  logic             ra_pop;
  logic             ra_write;
  logic [WIDTH-1:0] ra_i;
  logic             clear_flags;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic [WIDTH-1:0] at_o;
  logic [WIDTH-1:0] ra_o;
  logic [CW-1:0]    ra_count;
  logic             ra_empty;
  logic             ra_full;
  logic             ra_overflow;
  logic             ra_underflow;

  modport master (
    output write_hi, write_lo, write_at, hi_i, lo_i, at_i,
    output ra_push, ra_pop, ra_write, ra_i, clear_flags,
    input  hi_o, lo_o, at_o, ra_o, ra_count, ra_empty, ra_full, ra_overflow, ra_underflow
  );

  modport slave (
    input  write_hi, write_lo, write_at, hi_i, lo_i, at_i,
    input  ra_push, ra_pop, ra_write, ra_i, clear_flags,
    output hi_o, lo_o, at_o, ra_o, ra_count, ra_empty, ra_full, ra_overflow, ra_underflow
  );
endinterface

// File: rtl/special_reg_bank.sv
// HI/LO/AT registers plus a circular hardware return-address stack with sticky
// overflow/underflow flags. All state is registered; outputs derive from state only.
module special_reg_bank #(
  parameter int WIDTH    = 16,
  parameter int RA_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  special_reg_bank_if.slave bus
);
  localparam int CW = $clog2(RA_DEPTH + 1);
  localparam int PW = $clog2(RA_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(RA_DEPTH);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_at;
  logic [WIDTH-1:0] r_mem [RA_DEPTH];
  logic [PW-1:0]    r_tp;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic [PW-1:0]    w_tp_inc;
  logic [PW-1:0]    w_tp_dec;
  logic [PW-1:0]    w_tp_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_mem_we;
  logic [PW-1:0]    w_mem_addr;
  logic             w_ovf_set;
  logic             w_unf_set;

  assign w_empty  = (r_count == {CW{1'b0}});
  assign w_full   = (r_count == FULL_CNT);
  assign w_tp_inc = r_tp + PW'(1);
  assign w_tp_dec = r_tp - PW'(1);

  // Resolve the single stack action for this cycle (push+pop > push > pop > write).
  always_comb begin
    w_tp_nxt    = r_tp;
    w_count_nxt = r_count;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_tp;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    if (bus.ra_push && bus.ra_pop) begin
      w_mem_we = 1'b1;
      if (w_empty) begin
        w_tp_nxt    = w_tp_inc;
        w_mem_addr  = w_tp_inc;
        w_count_nxt = CW'(1);
      end else begin
        w_mem_addr  = r_tp;
      end
    end else if (bus.ra_push) begin
      // A push while full wraps onto the oldest entry; the count saturates.
      w_mem_we   = 1'b1;
      w_mem_addr = w_tp_inc;
      w_tp_nxt   = w_tp_inc;
      if (w_full) begin
        w_ovf_set = 1'b1;
      end else begin
        w_count_nxt = r_count + CW'(1);
      end
    end else if (bus.ra_pop) begin
      if (w_empty) begin
        w_unf_set = 1'b1;
      end else begin
        w_tp_nxt    = w_tp_dec;
        w_count_nxt = r_count - CW'(1);
      end
    end else if (bus.ra_write) begin
      w_mem_we = 1'b1;
      if (w_empty) begin
        w_tp_nxt    = w_tp_inc;
        w_mem_addr  = w_tp_inc;
        w_count_nxt = CW'(1);
      end else begin
        w_mem_addr  = r_tp;
      end
    end else begin
      w_mem_we = 1'b0;
    end
  end

  // HI/LO/AT registers with independent enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= {WIDTH{1'b0}};
      r_at <= {WIDTH{1'b0}};
    end else begin
      if (bus.write_hi) r_hi <= bus.hi_i;
      if (bus.write_lo) r_lo <= bus.lo_i;
      if (bus.write_at) r_at <= bus.at_i;
    end
  end

  // Return-stack storage, pointer, occupancy and sticky flags (a new error beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RA_DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
      r_tp    <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_mem_we) r_mem[w_mem_addr] <= bus.ra_i;
      r_tp    <= w_tp_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_set | (r_ovf & ~bus.clear_flags);
      r_unf   <= w_unf_set | (r_unf & ~bus.clear_flags);
    end
  end

  assign bus.hi_o         = r_hi;
  assign bus.lo_o         = r_lo;
  assign bus.at_o         = r_at;
  assign bus.ra_o         = w_empty ? {WIDTH{1'b0}} : r_mem[r_tp];
  assign bus.ra_count     = r_count;
  assign bus.ra_empty     = w_empty;
  assign bus.ra_full      = w_full;
  assign bus.ra_overflow  = r_ovf;
  assign bus.ra_underflow = r_unf;
endmodule
